// File: rtl/alu_pkg.sv
// Shared width and opcode encoding for the execute-stage ALU.
package alu_pkg;

    localparam int WIDTH = 19;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_MOD = 3'b100,
        OP_AND = 3'b101,
        OP_OR  = 3'b110,
        OP_XOR = 3'b111
    } alu_op_t;

endpackage

// File: rtl/alu_core_if.sv
// Operand/opcode bundle into the ALU and registered result/flags back out.
interface alu_core_if #(parameter int WIDTH = alu_pkg::WIDTH);

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             OverFlow;
    logic             Negative;

    modport master (
        output A, B, ALUControl,
        input  Result, Zero, OverFlow, Negative
    );

    modport slave (
        input  A, B, ALUControl,
        output Result, Zero, OverFlow, Negative
    );

endinterface

// File: rtl/alu_divmod.sv
// Single-cycle signed divider: quotient truncates toward zero, remainder takes the sign of A.
module alu_divmod #(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_div_zero,
    output logic             o_min_neg1
);

    logic w_div_zero;
    logic w_min_neg1;

    assign w_div_zero = (i_b == '0);
    assign w_min_neg1 = (i_a == {1'b1, {(WIDTH-1){1'b0}}}) && (i_b == '1);

    // min / -1 has no representable quotient; pin it to min so the wrap is explicit
    always_comb begin
        o_quot = '0;
        o_rem  = '0;
        if (w_div_zero) begin
            o_quot = '0;
            o_rem  = '0;
        end else if (w_min_neg1) begin
            o_quot = i_a;
            o_rem  = '0;
        end else begin
            o_quot = $signed(i_a) / $signed(i_b);
            o_rem  = $signed(i_a) % $signed(i_b);
        end
    end

    assign o_div_zero = w_div_zero;
    assign o_min_neg1 = w_min_neg1;

endmodule

// File: rtl/alu_core.sv
// Registered signed ALU: opcode mux, overflow detection and flag register, one-cycle latency.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic      clk,
    input  logic      rst,
    alu_core_if.slave bus
);

    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic               w_div_zero;
    logic               w_min_neg1;
    logic               w_mul_ovf;
    logic [WIDTH-1:0]   w_result;
    logic               w_ovf;
    alu_op_t            w_op;

    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_ovf;
    logic               r_neg;

    assign w_op   = alu_op_t'(bus.ALUControl);
    assign w_sum  = bus.A + bus.B;
    assign w_diff = bus.A - bus.B;

    // Sign-extended unsigned multiply yields the exact two's-complement product
    assign w_prod = {{WIDTH{bus.A[WIDTH-1]}}, bus.A} * {{WIDTH{bus.B[WIDTH-1]}}, bus.B};
    assign w_mul_ovf = !((w_prod[2*WIDTH-1:WIDTH-1] == '0) || (w_prod[2*WIDTH-1:WIDTH-1] == '1));

    alu_divmod #(.WIDTH(WIDTH)) u_divmod (
        .i_a        (bus.A),
        .i_b        (bus.B),
        .o_quot     (w_quot),
        .o_rem      (w_rem),
        .o_div_zero (w_div_zero),
        .o_min_neg1 (w_min_neg1)
    );

    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_result = w_sum;
                w_ovf    = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (w_sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                w_result = w_diff;
                w_ovf    = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (w_diff[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_MUL: begin
                w_result = w_prod[WIDTH-1:0];
                w_ovf    = w_mul_ovf;
            end
            OP_DIV: begin
                w_result = w_quot;
                w_ovf    = w_div_zero || w_min_neg1;
            end
            OP_MOD: begin
                w_result = w_rem;
                w_ovf    = w_div_zero;
            end
            OP_AND:  w_result = bus.A & bus.B;
            OP_OR:   w_result = bus.A | bus.B;
            OP_XOR:  w_result = bus.A ^ bus.B;
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_neg    <= 1'b0;
        end else begin
            r_result <= w_result;
            r_zero   <= (w_result == '0);
            r_ovf    <= w_ovf;
            r_neg    <= w_result[WIDTH-1];
        end
    end

    assign bus.Result   = r_result;
    assign bus.Zero     = r_zero;
    assign bus.OverFlow = r_ovf;
    assign bus.Negative = r_neg;

endmodule

// File: tb/tb_alu_core.sv
// Directed vector table plus reset sequences for the registered 19-bit ALU.
module tb_alu_core;

    localparam int W = 19;

    typedef struct {
        string          name;
        logic [2:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [W-1:0]   res;
        logic           z;
        logic           o;
        logic           n;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs[$];

    alu_core_if bus ();

    alu_core u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic add_vec(input string name, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] res,
                           input logic z, input logic o, input logic n);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b;
        v.res = res; v.z = z; v.o = o; v.n = n;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [W-1:0] res,
                         input logic z, input logic o, input logic n);
        n_cmp++;
        if (bus.Result !== res || bus.Zero !== z || bus.OverFlow !== o || bus.Negative !== n) begin
            n_err++;
            $display("FAIL %s: got R=%05h Z=%b O=%b N=%b, want R=%05h Z=%b O=%b N=%b",
                     name, bus.Result, bus.Zero, bus.OverFlow, bus.Negative, res, z, o, n);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.ALUControl = op;
        bus.A          = a;
        bus.B          = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        //       name         op      A         B         Result    Z     O     N
        add_vec("mod_26_5",   3'b100, 19'd26,   19'd5,    19'd1,    1'b0, 1'b0, 1'b0);
        add_vec("mul_10_2",   3'b010, 19'd10,   19'd2,    19'd20,   1'b0, 1'b0, 1'b0);
        add_vec("add_ovf",    3'b000, 19'h3FFFF,19'h00001,19'h40000,1'b0, 1'b1, 1'b1);
        add_vec("sub_zero",   3'b001, 19'd5,    19'd5,    19'd0,    1'b1, 1'b0, 1'b0);
        add_vec("div_m7_2",   3'b011, 19'h7FFF9,19'd2,    19'h7FFFD,1'b0, 1'b0, 1'b1);
        add_vec("mod_m7_2",   3'b100, 19'h7FFF9,19'd2,    19'h7FFFF,1'b0, 1'b0, 1'b1);
        add_vec("div_by0",    3'b011, 19'd9,    19'd0,    19'd0,    1'b1, 1'b1, 1'b0);
        add_vec("mod_by0",    3'b100, 19'd9,    19'd0,    19'd0,    1'b1, 1'b1, 1'b0);
        add_vec("div_min_m1", 3'b011, 19'h40000,19'h7FFFF,19'h40000,1'b0, 1'b1, 1'b1);
        add_vec("mod_min_m1", 3'b100, 19'h40000,19'h7FFFF,19'd0,    1'b1, 1'b0, 1'b0);
        add_vec("mul_ovf0",   3'b010, 19'd1024, 19'd1024, 19'd0,    1'b1, 1'b1, 1'b0);
        add_vec("xor_self",   3'b111, 19'h7FFFF,19'h7FFFF,19'd0,    1'b1, 1'b0, 1'b0);
        add_vec("and_mix",    3'b101, 19'h5A5A5,19'h0FF0F,19'h0A505,1'b0, 1'b0, 1'b0);
        add_vec("or_mix",     3'b110, 19'h40000,19'h00001,19'h40001,1'b0, 1'b0, 1'b1);
        add_vec("sub_ovf",    3'b001, 19'h40000,19'h00001,19'h3FFFF,1'b0, 1'b1, 1'b0);
        add_vec("add_negneg", 3'b000, 19'h7FFFF,19'h7FFFF,19'h7FFFE,1'b0, 1'b0, 1'b1);
        add_vec("add_negovf", 3'b000, 19'h40000,19'h7FFFF,19'h3FFFF,1'b0, 1'b1, 1'b0);
        add_vec("mul_m1_min", 3'b010, 19'h7FFFF,19'h40000,19'h40000,1'b0, 1'b1, 1'b1);
        add_vec("mul_m3_5",   3'b010, 19'h7FFFD,19'd5,    19'h7FFF1,1'b0, 1'b0, 1'b1);
        add_vec("div_m25_5",  3'b011, 19'h7FFE7,19'd5,    19'h7FFFB,1'b0, 1'b0, 1'b1);

        // Reset held two edges with a DIV pending, then released
        rst = 1'b1;
        drive(3'b011, 19'd25, 19'd5);
        @(posedge clk); #1 check("reset_edge1", '0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1 check("reset_edge2", '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1 check("div_25_5_after_rst", 19'd5, 1'b0, 1'b0, 1'b0);

        // Back-to-back issue: one new operation per edge
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            @(posedge clk); #1;
            check(vecs[i].name, vecs[i].res, vecs[i].z, vecs[i].o, vecs[i].n);
        end

        // Inputs changed mid-cycle are ignored until the next edge; outputs hold
        @(negedge clk); drive(3'b000, 19'd7, 19'd8);
        @(posedge clk); #1 check("add_7_8", 19'd15, 1'b0, 1'b0, 1'b0);
        drive(3'b001, 19'd0, 19'd1);
        #3 check("hold_between_edges", 19'd15, 1'b0, 1'b0, 1'b0);

        // Reset in the cycle after a valid op clears at the following edge
        @(negedge clk); drive(3'b000, 19'h3FFFF, 19'h00001);
        @(posedge clk); #1 check("add_before_rst", 19'h40000, 1'b0, 1'b1, 1'b1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1 check("rst_after_op", '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); rst = 1'b0; drive(3'b001, 19'd0, 19'd1);
        @(posedge clk); #1 check("sub_0_1", 19'h7FFFF, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
